// File: rtl/branch_predict_unit.sv
// branch_predict_unit: bimodal BHT/BTB lookup at fetch, branch resolution, training and redirect at execute.
// Tables are untagged and indexed by PC[IDX+1:2]; lookups see pre-edge contents.
module branch_predict_unit #(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [XLEN-1:0]      f_pc,
   output logic                 pred_taken,
   output logic [XLEN-1:0]      pred_target,
   input  logic                 e_valid,
   input  logic [XLEN-1:0]      e_pc,
   input  logic [31:0]          e_ir,
   input  logic [XLEN-1:0]      e_rs1,
   input  logic [XLEN-1:0]      e_rs2,
   input  logic                 e_pred_taken,
   input  logic [XLEN-1:0]      e_pred_target,
   output logic [1:0]           pc_source,
   output logic [XLEN-1:0]      br_target,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   input  logic                 cnt_clr,
   output logic [CNT_WIDTH-1:0] br_count,
   output logic [CNT_WIDTH-1:0] miss_count
);
   localparam int IDX = $clog2(BHT_DEPTH);

   logic [1:0]           ctr [BHT_DEPTH];
   logic [XLEN-1:0]      tgt [BHT_DEPTH];
   logic [BHT_DEPTH-1:0] vld;
   logic [IDX-1:0]       f_idx, e_idx;
   logic [6:0]           opcode;
   logic [2:0]           funct3;
   logic                 is_br, is_jal, is_jalr, cond, taken, mispredict;
   logic [XLEN-1:0]      imm_b, imm_j, imm_i, pc4, next_pc;
   logic [1:0]           ctr_e, ctr_nxt;
   logic                 unused_ok;

   assign f_idx       = f_pc[IDX+1:2];
   assign e_idx       = e_pc[IDX+1:2];
   assign pred_taken  = vld[f_idx] & ctr[f_idx][1];
   assign pred_target = tgt[f_idx];
   assign unused_ok   = ^{f_pc[XLEN-1:IDX+2], f_pc[1:0]};

   assign opcode  = e_ir[6:0];
   assign funct3  = e_ir[14:12];
   assign is_br   = opcode == 7'b1100011;
   assign is_jal  = opcode == 7'b1101111;
   assign is_jalr = opcode == 7'b1100111;
   assign imm_b   = {{(XLEN-13){e_ir[31]}}, e_ir[31], e_ir[7], e_ir[30:25], e_ir[11:8], 1'b0};
   assign imm_j   = {{(XLEN-21){e_ir[31]}}, e_ir[31], e_ir[19:12], e_ir[20], e_ir[30:21], 1'b0};
   assign imm_i   = {{(XLEN-12){e_ir[31]}}, e_ir[31:20]};
   assign pc4     = e_pc + XLEN'(4);

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000: cond = e_rs1 == e_rs2;
         3'b001: cond = e_rs1 != e_rs2;
         3'b100: cond = $signed(e_rs1) < $signed(e_rs2);
         3'b101: cond = $signed(e_rs1) >= $signed(e_rs2);
         3'b110: cond = e_rs1 < e_rs2;
         3'b111: cond = e_rs1 >= e_rs2;
         default: cond = 1'b0;
      endcase
   end

   assign taken      = (is_br & cond) | is_jal | is_jalr;
   assign br_target  = is_br ? e_pc + imm_b :
                       is_jal ? e_pc + imm_j :
                       is_jalr ? (e_rs1 + imm_i) & ~XLEN'(1) : pc4;
   // pc_source steers the fetch mux, so a not-taken branch selects PC+4
   assign pc_source  = !e_valid ? 2'b00 :
                       is_jalr ? 2'b11 :
                       is_jal ? 2'b10 :
                       (is_br & cond) ? 2'b01 : 2'b00;
   assign next_pc    = taken ? br_target : pc4;
   assign mispredict = (taken != e_pred_taken) | (taken & (e_pred_target != br_target));
   assign ctr_e      = ctr[e_idx];
   assign ctr_nxt    = taken ? (&ctr_e ? ctr_e : ctr_e + 2'd1) : (|ctr_e ? ctr_e - 2'd1 : ctr_e);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            ctr[i] <= 2'b01;
            tgt[i] <= '0;
         end
         vld <= '0;
      end else if (e_valid) begin
         if (is_br) begin
            ctr[e_idx] <= ctr_nxt;
            if (taken) begin
               tgt[e_idx] <= br_target;
               vld[e_idx] <= 1'b1;
            end
         end else if (is_jal) begin
            ctr[e_idx] <= 2'b11;
            tgt[e_idx] <= br_target;
            vld[e_idx] <= 1'b1;
         end else if (!is_jalr && e_pred_taken) begin
            vld[e_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= e_valid & mispredict;
         redirect_pc    <= next_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count   <= '0;
         miss_count <= '0;
      end else if (cnt_clr) begin
         br_count   <= '0;
         miss_count <= '0;
      end else if (e_valid) begin
         if ((is_br | is_jal | is_jalr) && !(&br_count)) br_count <= br_count + CNT_WIDTH'(1);
         if (mispredict && !(&miss_count)) miss_count <= miss_count + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: vector table driven through a redirect scoreboard, plus lookup and reset corner sequences.
module tb_branch_predict_unit;
   logic        clk = 0, rst_n = 0;
   logic [31:0] f_pc = 0, e_pc = 0, e_ir = 0, e_rs1 = 0, e_rs2 = 0, e_pred_target = 0;
   logic        e_valid = 0, e_pred_taken = 0, cnt_clr = 0;
   logic        pred_taken, redirect_valid;
   logic [31:0] pred_target, br_target, redirect_pc;
   logic [1:0]  pc_source;
   logic [3:0]  br_count, miss_count;

   branch_predict_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .e_valid(e_valid), .e_pc(e_pc), .e_ir(e_ir), .e_rs1(e_rs1), .e_rs2(e_rs2),
      .e_pred_taken(e_pred_taken), .e_pred_target(e_pred_target), .pc_source(pc_source),
      .br_target(br_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .cnt_clr(cnt_clr), .br_count(br_count), .miss_count(miss_count));

   always #5 clk = ~clk;

   typedef struct {
      logic v; logic [31:0] ir, pc, rs1, rs2; logic pt; logic [31:0] ptgt;
      logic cs; logic [1:0] src; logic [31:0] tgt; logic rd; logic [31:0] rpc;
   } vec_t;

   vec_t tv[$];
   vec_t sb[$];
   int total = 0, bad = 0;
   logic [3:0] exp_br = 0, exp_miss = 0;

   localparam logic [31:0] ADD = 32'h0000_0033;

   function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
      return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction
   function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
      return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
   endfunction

   function automatic vec_t mk(input logic v, input logic [31:0] ir, pc, rs1, rs2, input logic pt,
                               input logic [31:0] ptgt, input logic cs, input logic [1:0] src,
                               input logic [31:0] tgt, input logic rd, input logic [31:0] rpc);
      vec_t t;
      t.v = v; t.ir = ir; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.pt = pt; t.ptgt = ptgt;
      t.cs = cs; t.src = src; t.tgt = tgt; t.rd = rd; t.rpc = rpc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic lookup(input logic [31:0] pc, input logic et, input logic [31:0] etgt);
      f_pc = pc;
      #1;
      chk($sformatf("pred_taken@%h", pc), {31'd0, pred_taken}, {31'd0, et});
      if (et) chk($sformatf("pred_target@%h", pc), pred_target, etgt);
   endtask

   task automatic apply(input vec_t t);
      vec_t e;
      logic ctl;
      e_valid = t.v; e_ir = t.ir; e_pc = t.pc; e_rs1 = t.rs1; e_rs2 = t.rs2;
      e_pred_taken = t.pt; e_pred_target = t.ptgt;
      #1;
      if (t.cs) chk($sformatf("pc_source@%h", t.pc), {30'd0, pc_source}, {30'd0, t.src});
      chk($sformatf("br_target@%h", t.pc), br_target, t.tgt);
      sb.push_back(t);
      ctl = t.ir[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
      if (cnt_clr) begin
         exp_br = 0; exp_miss = 0;
      end else if (t.v) begin
         if (ctl && exp_br != 4'hF) exp_br++;
         if (t.rd && exp_miss != 4'hF) exp_miss++;
      end
      @(posedge clk);
      #1;
      e_valid = 0;
      e = sb.pop_front();
      chk($sformatf("redirect_valid@%h", e.pc), {31'd0, redirect_valid}, {31'd0, e.v & e.rd});
      if (e.v & e.rd) chk($sformatf("redirect_pc@%h", e.pc), redirect_pc, e.rpc);
      chk("br_count", {28'd0, br_count}, {28'd0, exp_br});
      chk("miss_count", {28'd0, miss_count}, {28'd0, exp_miss});
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      lookup(32'h100, 1'b0, 32'h0);
      chk("reset pred_target", pred_target, 32'h0);
      chk("reset br_count", {28'd0, br_count}, 32'h0);
      chk("reset miss_count", {28'd0, miss_count}, 32'h0);
      chk("reset redirect_valid", {31'd0, redirect_valid}, 32'h0);
      rst_n = 1;

      // BEQ trains idx 0 towards taken
      tv.push_back(mk(1, enc_b(3'b000, 13'h020), 32'h100, 5, 5, 0, 0, 1, 2'b01, 32'h120, 1, 32'h120));
      tv.push_back(mk(1, enc_b(3'b000, 13'h020), 32'h100, 5, 5, 0, 0, 1, 2'b01, 32'h120, 1, 32'h120));
      foreach (tv[i]) apply(tv[i]);
      lookup(32'h100, 1'b1, 32'h120);

      // signed BLT taken x4 saturates at 11, unsigned BLTU not taken x5 saturates at 00
      tv.delete();
      tv.push_back(mk(1, enc_b(3'b100, 13'h040), 32'h204, 32'hFFFF_FFFF, 1, 0, 0, 1, 2'b01, 32'h244, 1, 32'h244));
      for (int i = 0; i < 3; i++)
         tv.push_back(mk(1, enc_b(3'b100, 13'h040), 32'h204, 32'hFFFF_FFFF, 1, 1, 32'h244, 1, 2'b01, 32'h244, 0, 32'h244));
      foreach (tv[i]) apply(tv[i]);
      lookup(32'h204, 1'b1, 32'h244);
      tv.delete();
      for (int i = 0; i < 5; i++)
         tv.push_back(mk(1, enc_b(3'b110, 13'h040), 32'h204, 32'hFFFF_FFFF, 1, i < 2, i < 2 ? 32'h244 : 0,
                         0, 2'b00, 32'h244, i < 2, 32'h208));
      foreach (tv[i]) apply(tv[i]);
      lookup(32'h204, 1'b0, 32'h0);

      // JALR at an index aliasing the BEQ entry, JAL train, ADD cleanup, invalid slot
      tv.delete();
      tv.push_back(mk(1, enc_jalr(12'h004), 32'h300, 32'h203, 0, 1, 32'h206, 1, 2'b11, 32'h206, 0, 32'h206));
      tv.push_back(mk(1, enc_jalr(12'h004), 32'h300, 32'h203, 0, 0, 0, 1, 2'b11, 32'h206, 1, 32'h206));
      foreach (tv[i]) apply(tv[i]);
      lookup(32'h100, 1'b1, 32'h120);
      apply(mk(1, enc_j(21'h1F_FFF8), 32'h408, 0, 0, 0, 0, 1, 2'b10, 32'h400, 1, 32'h400));
      lookup(32'h408, 1'b1, 32'h400);
      apply(mk(1, ADD, 32'h408, 0, 0, 1, 32'h400, 1, 2'b00, 32'h40C, 1, 32'h40C));
      lookup(32'h408, 1'b0, 32'h0);
      apply(mk(0, enc_b(3'b000, 13'h020), 32'h900, 3, 3, 1, 32'h0, 1, 2'b00, 32'h920, 0, 32'h0));
      lookup(32'h100, 1'b1, 32'h120);

      // remaining funct3 cases, incl. a backward BGEU; branch count saturates at 0xF
      tv.delete();
      tv.push_back(mk(1, enc_b(3'b010, 13'h010), 32'h500, 1, 1, 0, 0, 0, 2'b00, 32'h510, 0, 32'h504));
      tv.push_back(mk(1, enc_b(3'b001, 13'h008), 32'h600, 7, 7, 0, 0, 0, 2'b00, 32'h608, 0, 32'h604));
      tv.push_back(mk(1, enc_b(3'b101, 13'h010), 32'h700, 32'hFFFF_FFFF, 1, 0, 0, 0, 2'b00, 32'h710, 0, 32'h704));
      tv.push_back(mk(1, enc_b(3'b111, 13'h1FF0), 32'h800, 32'hFFFF_FFFF, 1, 0, 0, 1, 2'b01, 32'h7F0, 1, 32'h7F0));
      foreach (tv[i]) apply(tv[i]);
      chk("br_count saturated", {28'd0, br_count}, 32'hF);

      // clear beats a same-cycle increment
      cnt_clr = 1;
      apply(mk(1, enc_b(3'b000, 13'h020), 32'hA00, 1, 1, 0, 0, 1, 2'b01, 32'hA20, 1, 32'hA20));
      cnt_clr = 0;
      chk("cnt_clr br_count", {28'd0, br_count}, 32'h0);

      // async reset drops a pending redirect
      apply(mk(1, ADD, 32'hB00, 0, 0, 1, 32'h1234, 1, 2'b00, 32'hB04, 1, 32'hB04));
      rst_n = 0;
      #1;
      chk("reset redirect_valid", {31'd0, redirect_valid}, 32'h0);
      chk("reset redirect_pc", redirect_pc, 32'h0);
      chk("reset miss_count", {28'd0, miss_count}, 32'h0);
      lookup(32'h100, 1'b0, 32'h0);
      chk("reset pred_target", pred_target, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
